arb_rr_16_2_bit: RTL and testbench
==================================

# arb_rr_16_2_bit

Round-robin arbiter and sequencer for a shared 16-input, 2-bit-wide select datapath. It accepts requests from 16 sources and grants one source at a time. It drives the 4-bit select of the `mux_16_2_bit` instance and presents the selected 2-bit payload to a single consumer through a valid/ready handshake. Each grant covers a burst of up to `MAX_BEATS` transfers, after which priority rotates to the next source.

## Interface
- `MAX_BEATS`, 4: maximum transfers per grant; legal range 1..8.
- `CNT_W`, 3: beat-counter width; must satisfy 2^`CNT_W` >= `MAX_BEATS`.

Ports:
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in 16: `req[i]` high means source i has data.
- `in_data` in 32: packed payloads; source i drives bits [2i+1:2i].
- `out_ready` in 1: consumer accepts a beat this cycle.
- `out_valid` out 1: `out_data` holds a valid beat.
- `out_data` out 2: payload of the granted source; 2'b00 whenever `out_valid` is 0.
- `out_sel` out 4: index of the current/last granted source; this is the mux select.
- `grant` out 16: one-hot current grant; all zero in IDLE.

## Operation
- State machine with two states, IDLE and GRANT.
- Registered state: `state`, `sel[3:0]`, `ptr[3:0]` (highest-priority index), `cnt[CNT_W-1:0]`.
- Reset values:
  - `state` = IDLE; `ptr` = 0; `sel` = 0; `cnt` = 0.
  - Outputs after reset: `out_valid` = 0, `out_data` = 0, `out_sel` = 0, `grant` = 0.
- IDLE behaviour:
  - If `req` is nonzero, pick the first i with `req[i]` = 1, searching `ptr`, `ptr`+1, … mod 16 (wraps 15→0).
  - Load `sel` = i and `cnt` = 0, then go to GRANT.
  - If `req` = 0, stay in IDLE; `ptr` is unchanged.
- GRANT outputs (combinational):
  - `grant` = 1 << `sel`.
  - `out_valid` = `req[sel]`.
  - `out_data` = `in_data[2*sel+1:2*sel]` through `mux_16_2_bit`, gated to 0 when `out_valid` = 0.
- A transfer occurs when `out_valid` & `out_ready`.
- GRANT transitions:
  - Transfer with `cnt` = `MAX_BEATS`-1: release. Go to IDLE; `ptr` = `sel`+1 mod 16.
  - Transfer with `cnt` < `MAX_BEATS`-1: `cnt` increments; stay in GRANT.
  - `req[sel]` = 0: release immediately with no transfer. Go to IDLE; `ptr` = `sel`+1 mod 16.
  - `out_valid` = 1 and `out_ready` = 0: hold. `sel`, `cnt` and the payload path are unchanged.
- Changes on other `req` bits during GRANT are ignored until release.
- `reset` during GRANT abandons the burst. The next cycle is IDLE with `ptr` = 0, and no transfer is reported in the reset cycle.
- Requesters may change payload between beats. A beat is consumed only on a transfer cycle.

## Timing
- A request sampled in IDLE at edge N gives `out_valid` = 1 in the cycle after edge N (1-cycle arbitration latency).
- Each release is followed by exactly one IDLE cycle; the throughput bound is `MAX_BEATS` beats per `MAX_BEATS`+1 cycles.
- `out_sel` and `grant` are stable for the entire GRANT period. `out_sel` retains `sel` in IDLE.
- There is no combinational path from `out_ready` to `out_valid`. `req[sel]` to `out_valid` is combinational.

## Structure
- Shared include `arb_defs.vh`:
  - `NUM_REQ` = 16, `SEL_W` = 4, `DATA_W` = 2.
  - State encodings `ST_IDLE` = 1'b0, `ST_GRANT` = 1'b1.
- One sub-module, `rr_pick_16`: combinational rotate-priority finder.
  - Inputs: `req[15:0]`, `ptr[3:0]`.
  - Outputs: `found`, `idx[3:0]`.
- Data path reuses the existing `mux_16_2_bit`, with `out_sel` driving its select.

## Test plan
- **Single source:** `req` = 16'h0008, `out_ready` = 1, `in_data[7:6]` = 2'b10, `MAX_BEATS` = 4 → `out_sel` = 3; `out_data` = 2'b10 for 4 consecutive beats; one IDLE cycle; `ptr` = 4; regrant to 3.
- **Rotation and wrap:** `req` = 16'h8001 held, `ptr` = 0, `MAX_BEATS` = 1 → grant order 0, 15, 0, 15, with one IDLE cycle between grants.
- **Backpressure:** grant to 5, `out_ready` low for 3 cycles → `out_valid` = 1, `out_sel` = 5 and `cnt` = 0 throughout; the beat transfers on the first `out_ready`-high cycle.
- **Early drop:** grant to 9, `req[9]` falls after 1 transfer → `out_valid` = 0 in that same cycle; next cycle IDLE; `ptr` = 10.
- **Reset mid-burst:** grant to 12 after 2 beats, `reset` for 1 cycle with `req` = 16'hFFFF → next grant goes to 0, not 13.
- **All request:** `req` = 16'hFFFF, `MAX_BEATS` = 2 → grants 0..15 in order, 2 beats each, then wrap to 0.

Source files
------------

// File: rtl/arb_rr_16_2_bit_pkg.sv
// Shared widths and FSM encoding for the 16-source round-robin arbiter slice.
package arb_rr_16_2_bit_pkg;

    localparam int NUM_REQ = 16;
    localparam int SEL_W   = 4;
    localparam int DATA_W  = 2;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

endpackage

// File: rtl/mux_16_2_bit.sv
// 16:1 mux of 2-bit payloads; purely combinational, zero latency.
// No flow control: the select is held stable by the arbiter for a whole grant.
module mux_16_2_bit
    import arb_rr_16_2_bit_pkg::*;
(
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]          sel,
    output logic [DATA_W-1:0]         out_data
);

    assign out_data = in_data[{sel, 1'b0} +: DATA_W];

endmodule

// File: rtl/rr_pick_16.sv
// Rotate-priority finder: first set request at or after ptr, wrapping 15->0.
// Combinational, zero latency; no flow control.
module rr_pick_16
    import arb_rr_16_2_bit_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic               found,
    output logic [SEL_W-1:0]   idx
);

    // Walk from farthest to nearest so the closest hit to ptr overwrites the rest.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[ptr + SEL_W'(k)]) begin
                found = 1'b1;
                idx   = ptr + SEL_W'(k);
            end
        end
    end

endmodule

// File: rtl/arb_rr_16_2_bit.sv
// Round-robin arbiter over 16 sources, bursts of up to MAX_BEATS beats; 1-cycle arbitration, one IDLE cycle per release.
// out_ready low holds the beat and the burst counter; out_valid never depends on out_ready.
module arb_rr_16_2_bit
    import arb_rr_16_2_bit_pkg::*;
#(
    parameter int MAX_BEATS = 4,
    parameter int CNT_W     = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] in_data,
    input  logic                      out_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic [SEL_W-1:0]          out_sel,
    output logic [NUM_REQ-1:0]        grant
);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(MAX_BEATS - 1);

    state_t             r_state;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_ptr;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_found;
    logic [SEL_W-1:0]   w_idx;
    logic [DATA_W-1:0]  w_mux_dat;
    logic               w_in_grant;
    logic               w_xfer;

    rr_pick_16 u_pick (
        .req   (req),
        .ptr   (r_ptr),
        .found (w_found),
        .idx   (w_idx)
    );

    mux_16_2_bit u_mux (
        .in_data  (in_data),
        .sel      (out_sel),
        .out_data (w_mux_dat)
    );

    assign w_in_grant = (r_state == ST_GRANT);
    // A burst abandoned by reset must not report a beat in the reset cycle.
    assign out_valid  = w_in_grant & req[r_sel] & ~reset;
    assign out_data   = out_valid ? w_mux_dat : '0;
    assign out_sel    = r_sel;
    assign grant      = w_in_grant ? (NUM_REQ'(1) << r_sel) : '0;
    assign w_xfer     = out_valid & out_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_sel   <= w_idx;
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!req[r_sel]) begin
                        r_state <= ST_IDLE;
                        r_ptr   <= r_sel + SEL_W'(1);
                    end else if (w_xfer) begin
                        if (r_cnt == LAST_BEAT) begin
                            r_state <= ST_IDLE;
                            r_ptr   <= r_sel + SEL_W'(1);
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_arb_rr_16_2_bit.sv
// Bench for arb_rr_16_2_bit: directed vector table, burst-order sequences, random run against a reference model.
module tb_arb_rr_16_2_bit;

    localparam int MB = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] req;
    logic [31:0] in_data;
    logic        out_ready;
    logic        out_valid;
    logic [1:0]  out_data;
    logic [3:0]  out_sel;
    logic [15:0] grant;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    arb_rr_16_2_bit #(.MAX_BEATS(MB), .CNT_W(3)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .grant     (grant)
    );

    typedef struct {
        logic        rst;
        logic [15:0] rq;
        logic [31:0] dat;
        logic        rdy;
        logic [22:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic [15:0] rq, logic [31:0] dat, logic rdy,
                                logic ev, logic [1:0] ed, logic [3:0] es, logic [15:0] eg);
        vec_t v;
        v.rst = rst; v.rq = rq; v.dat = dat; v.rdy = rdy;
        v.exp = {ev, ed, es, eg};
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Compare the four outputs mid-cycle, then advance one clock.
    task automatic check_cyc(string nm, logic [22:0] exp);
        logic [22:0] act;
        #4;
        act = {out_valid, out_data, out_sel, grant};
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got valid=%b data=%b sel=%0d grant=%h, required valid=%b data=%b sel=%0d grant=%h",
                     nm, act[22], act[21:20], act[19:16], act[15:0],
                     exp[22], exp[21:20], exp[19:16], exp[15:0]);
        end
        tick();
    endtask

    // Reference model: which source holds the bus, beats it has used, where the search starts next.
    bit m_busy;
    int m_sel, m_ptr, m_beats;

    function automatic logic [22:0] m_out();
        logic       v;
        logic [1:0] d;
        logic [15:0] g;
        v = m_busy && req[m_sel] && !reset;
        d = v ? in_data[2*m_sel +: 2] : 2'b00;
        g = m_busy ? (16'd1 << m_sel) : 16'd0;
        return {v, d, 4'(m_sel), g};
    endfunction

    function automatic void m_step();
        if (reset) begin
            m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
        end else if (!m_busy) begin
            for (int k = 0; k < 16; k++) begin
                if (req[(m_ptr + k) % 16]) begin
                    m_sel = (m_ptr + k) % 16;
                    m_beats = 0;
                    m_busy = 1;
                    break;
                end
            end
        end else if (!req[m_sel]) begin
            m_busy = 0;
            m_ptr = (m_sel + 1) % 16;
        end else if (out_ready) begin
            m_beats++;
            if (m_beats == MB) begin
                m_busy = 0;
                m_ptr = (m_sel + 1) % 16;
            end
        end
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        req = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] d0, d1, d2;
        logic [3:0]  s;
        d0 = 32'h0000_0380;
        d1 = 32'h0000_0780;
        d2 = 32'h0200_0780;

        tbl.push_back(mk(0, 16'h0000, d0, 1, 0, 2'd0, 4'd0,  16'h0000));
        tbl.push_back(mk(0, 16'h0008, d0, 1, 0, 2'd0, 4'd0,  16'h0000));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 16'h0008, d0, 1, 1, 2'd2, 4'd3, 16'h0008));
        tbl.push_back(mk(0, 16'h0018, d0, 1, 0, 2'd0, 4'd3,  16'h0000));
        tbl.push_back(mk(0, 16'h0018, d0, 1, 1, 2'd3, 4'd4,  16'h0010));
        tbl.push_back(mk(0, 16'h0008, d0, 1, 0, 2'd0, 4'd4,  16'h0010));
        tbl.push_back(mk(0, 16'h0020, d1, 1, 0, 2'd0, 4'd4,  16'h0000));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(0, 16'h0020, d1, 0, 1, 2'd1, 4'd5, 16'h0020));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0, 16'h0020, d1, 1, 1, 2'd1, 4'd5, 16'h0020));
        tbl.push_back(mk(0, 16'h1000, d2, 1, 0, 2'd0, 4'd5,  16'h0000));
        for (int i = 0; i < 2; i++)
            tbl.push_back(mk(0, 16'h1000, d2, 1, 1, 2'd2, 4'd12, 16'h1000));
        tbl.push_back(mk(1, 16'hFFFF, d2, 1, 0, 2'd0, 4'd12, 16'h1000));
        tbl.push_back(mk(0, 16'hFFFF, d2, 0, 0, 2'd0, 4'd0,  16'h0000));
        tbl.push_back(mk(0, 16'hFFFF, d2, 0, 1, 2'd0, 4'd0,  16'h0001));

        reset = 1'b1; req = '0; in_data = '0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        foreach (tbl[i]) begin
            reset = tbl[i].rst;
            req = tbl[i].rq;
            in_data = tbl[i].dat;
            out_ready = tbl[i].rdy;
            check_cyc($sformatf("vec%0d", i), tbl[i].exp);
        end
        reset = 1'b0;

        // Source i carries payload i%4, so data also identifies the granted source.
        do_reset();
        req = 16'hFFFF; in_data = 32'hE4E4_E4E4; out_ready = 1'b1;
        check_cyc("allreq_idle0", {1'b0, 2'd0, 4'd0, 16'h0000});
        for (int g = 0; g < 17; g++) begin
            s = 4'(g % 16);
            for (int b = 0; b < MB; b++)
                check_cyc($sformatf("allreq_g%0d_b%0d", g, b), {1'b1, 2'(g % 4), s, 16'd1 << s});
            check_cyc($sformatf("allreq_gap%0d", g), {1'b0, 2'd0, s, 16'h0000});
        end

        do_reset();
        req = 16'h8001; in_data = 32'hE4E4_E4E4; out_ready = 1'b1;
        check_cyc("rot_idle0", {1'b0, 2'd0, 4'd0, 16'h0000});
        for (int g = 0; g < 4; g++) begin
            s = (g % 2 == 1) ? 4'd15 : 4'd0;
            for (int b = 0; b < MB; b++)
                check_cyc($sformatf("rot_g%0d_b%0d", g, b), {1'b1, 2'(s % 4), s, 16'd1 << s});
            check_cyc($sformatf("rot_gap%0d", g), {1'b0, 2'd0, s, 16'h0000});
        end

        do_reset();
        m_busy = 0; m_sel = 0; m_ptr = 0; m_beats = 0;
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if ($urandom_range(0, 7) == 0) begin
                case ($urandom_range(0, 3))
                    0: req = 16'h0000;
                    1: req = 16'd1 << $urandom_range(0, 15);
                    2: req = 16'hFFFF;
                    default: req = 16'($urandom);
                endcase
            end
            in_data = $urandom;
            out_ready = ($urandom_range(0, 3) != 0);
            #4;
            n_vec++;
            if ({out_valid, out_data, out_sel, grant} !== m_out()) begin
                n_err++;
                $display("FAIL rand%0d: got valid=%b data=%b sel=%0d grant=%h, required %h",
                         c, out_valid, out_data, out_sel, grant, m_out());
            end
            m_step();
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
